// File: rtl/accum_bs_if.sv
// accum_bs_if: product/result handshake bus between FMULT, the predictor-sum
// accumulator and its downstream consumer.
//   wan_in/in_valid/in_ready : product stream into the accumulator
//   prod_idx                 : index of the next product the accumulator expects
//   sez/se/out_valid/out_ready : result handshake out of the accumulator
// master = producer/consumer side (testbench or surrounding datapath),
// slave  = accumulator side.
interface accum_bs_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] wan_in;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       prod_idx;
   logic [WIDTH-2:0] sez;
   logic [WIDTH-2:0] se;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output wan_in, in_valid, out_ready,
      input  in_ready, prod_idx, sez, se, out_valid
   );

   modport slave (
      input  wan_in, in_valid, out_ready,
      output in_ready, prod_idx, sez, se, out_valid
   );
endinterface

// File: rtl/accum_bs.sv
// accum_bs: G.726 predictor-sum accumulator behind FMULT.
// Sums N_ZERO zero-section products (WB1..WBn) into SEZI, then N_POLE
// pole-section products (WA1..WAn) on top of that to form SEI. Emits
// SEZ = SEZI[WIDTH-1:1] and SE = SEI[WIDTH-1:1], held until taken.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   scan_enable, scan_in0, scan_out0 : DFT hooks, chain stitched later
//   flush           : synchronous abort of a partial frame / pending result
//   bus (slave)     : product input and result output handshakes
// The bus interface must be instantiated with the same WIDTH as this module.
module accum_bs #(
   parameter int WIDTH  = 16,
   parameter int N_ZERO = 6,
   parameter int N_POLE = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          scan_enable,
   input  logic          scan_in0,
   output logic          scan_out0,
   input  logic          flush,
   accum_bs_if.slave     bus
);

   localparam logic [3:0] LAST_ZERO = 4'(N_ZERO - 1);
   localparam logic [3:0] LAST_PROD = 4'(N_ZERO + N_POLE - 1);

   typedef enum logic {ACC, OUT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sezi_q, sezi_d;
   logic [3:0]       idx_q, idx_d;
   logic [WIDTH-2:0] sez_q, sez_d;
   logic [WIDTH-2:0] se_q, se_d;
   logic             ov_q, ov_d;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] sezi_src;
   logic             in_ready;

   // Scan chain is inserted at synthesis; RTL only ties off the output.
   assign scan_out0 = 1'b0;
   wire unused_scan = &{1'b0, scan_enable, scan_in0};

   // Modular add: carry out of the top bit is intentionally dropped.
   assign sum      = acc_q + bus.wan_in;
   // When the last WB and the last product coincide (N_POLE=0) SEZI is the
   // sum being formed this cycle, not the registered copy.
   assign sezi_src = (idx_q == LAST_ZERO) ? sum : sezi_q;
   assign in_ready = (state_q == ACC) && !flush;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sezi_d  = sezi_q;
      idx_d   = idx_q;
      sez_d   = sez_q;
      se_d    = se_q;
      ov_d    = ov_q;
      if (flush) begin
         // Any result handshake in this cycle has already completed on the
         // bus; clearing here just discards the frame state.
         state_d = ACC;
         acc_d   = '0;
         sezi_d  = '0;
         idx_d   = '0;
         ov_d    = 1'b0;
      end else begin
         case (state_q)
            ACC: begin
               if (bus.in_valid) begin
                  acc_d = sum;
                  idx_d = idx_q + 4'd1;
                  if (idx_q == LAST_ZERO) sezi_d = sum;
                  if (idx_q == LAST_PROD) begin
                     sez_d   = sezi_src[WIDTH-1:1];
                     se_d    = sum[WIDTH-1:1];
                     ov_d    = 1'b1;
                     idx_d   = '0;
                     state_d = OUT;
                  end
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  ov_d    = 1'b0;
                  acc_d   = '0;
                  sezi_d  = '0;
                  state_d = ACC;
               end
            end
            default: state_d = ACC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ACC;
         acc_q   <= '0;
         sezi_q  <= '0;
         idx_q   <= '0;
         sez_q   <= '0;
         se_q    <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sezi_q  <= sezi_d;
         idx_q   <= idx_d;
         sez_q   <= sez_d;
         se_q    <= se_d;
         ov_q    <= ov_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.prod_idx  = idx_q;
   assign bus.sez       = sez_q;
   assign bus.se        = se_q;
   assign bus.out_valid = ov_q;

endmodule

// File: tb/tb_accum_bs.sv
// tb_accum_bs: directed vectors with hand-computed SEZ/SE for accum_bs.
module tb_accum_bs;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic scan_enable = 1'b0;
   logic scan_in0 = 1'b0;
   logic scan_out0;
   logic flush = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   accum_bs_if #(.WIDTH(16)) bus ();

   accum_bs #(.WIDTH(16), .N_ZERO(6), .N_POLE(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .scan_enable (scan_enable),
      .scan_in0    (scan_in0),
      .scan_out0   (scan_out0),
      .flush       (flush),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Present one product and hold it until accepted (bounded wait).
   task automatic push(input logic [15:0] v);
      int k;
      bus.wan_in   = v;
      bus.in_valid = 1'b1;
      #1;
      k = 0;
      while (!bus.in_ready && k < 50) begin
         tick();
         k++;
      end
      if (k == 50) chk("push_timeout", 32'd0, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.wan_in   = '0;
   endtask

   // Feed one frame (v[0] first); optional idle cycle after the 4th product.
   task automatic run_frame(input string tag, input logic [7:0][15:0] v, input bit gap,
                            input logic [14:0] esez, input logic [14:0] ese);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk({tag, "_ov_pre"}, 32'(bus.out_valid), 32'd0);
         push(v[i]);
         if (gap && i == 3) tick();
      end
      chk({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_sez"}, 32'(bus.sez), 32'(esez));
      chk({tag, "_se"}, 32'(bus.se), 32'(ese));
   endtask

   task automatic consume(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      #1;
      chk({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      logic [7:0][15:0] v;
      logic [14:0] held_sez;
      logic [14:0] held_se;
      bus.wan_in    = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_ov", 32'(bus.out_valid), 32'd0);
      chk("rst_idx", 32'(bus.prod_idx), 32'd0);
      chk("rst_sez", 32'(bus.sez), 32'd0);
      chk("rst_se", 32'(bus.se), 32'd0);
      chk("rst_rdy", 32'(bus.in_ready), 32'd1);

      // 1: reset mid-frame, then a frame of zeros
      push(16'h1111); push(16'h2222); push(16'h3333);
      chk("t1_idx3", 32'(bus.prod_idx), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("t1_ov", 32'(bus.out_valid), 32'd0);
      chk("t1_idx", 32'(bus.prod_idx), 32'd0);
      v = '0;
      run_frame("t1", v, 1'b0, 15'h0000, 15'h0000);
      consume("t1");

      // 2: WB=2, WA=4, with an idle cycle mid-frame
      v = {16'h0004, 16'h0004, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002};
      run_frame("t2", v, 1'b1, 15'h0006, 15'h000A);
      consume("t2");

      // 3: single -2 product
      v = '0;
      v[0] = 16'hFFFE;
      run_frame("t3", v, 1'b0, 15'h7FFF, 15'h7FFF);
      consume("t3");

      // 4: WB sum wraps to 16'hA000
      v = {16'h0000, 16'h0000, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000};
      run_frame("t4", v, 1'b0, 15'h5000, 15'h5000);
      consume("t4");

      // 5: backpressure on the result with in_valid high
      v = {16'h0004, 16'h0004, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002};
      run_frame("t5", v, 1'b0, 15'h0006, 15'h000A);
      held_sez = bus.sez;
      held_se  = bus.se;
      bus.wan_in   = 16'h1234;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t5_rdy0", 32'(bus.in_ready), 32'd0);
         chk("t5_ovh", 32'(bus.out_valid), 32'd1);
         chk("t5_sezh", 32'(bus.sez), 32'h0006);
         chk("t5_seh", 32'(bus.se), 32'h000A);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.wan_in   = '0;
      consume("t5");
      chk("t5_idx", 32'(bus.prod_idx), 32'd0);
      chk("t5_held", 32'({held_sez, held_se}), 32'({15'h0006, 15'h000A}));
      v = {16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0008};
      run_frame("t5b", v, 1'b0, 15'h0004, 15'h000C);
      consume("t5b");

      // 6: flush at prod_idx=4 with a product offered
      push(16'h0100); push(16'h0200); push(16'h0300); push(16'h0400);
      chk("t6_idx4", 32'(bus.prod_idx), 32'd4);
      bus.wan_in   = 16'h0500;
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      #1;
      chk("t6_rdy", 32'(bus.in_ready), 32'd0);
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      bus.wan_in   = '0;
      #1;
      chk("t6_idx", 32'(bus.prod_idx), 32'd0);
      chk("t6_ov", 32'(bus.out_valid), 32'd0);
      // WB=1..6 -> SEZI=0x15, WA=0x10,0x20 -> SEI=0x45
      v = {16'h0020, 16'h0010, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
      run_frame("t6", v, 1'b0, 15'h000A, 15'h0022);

      // flush while a result is pending clears it
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("t7_ov", 32'(bus.out_valid), 32'd0);
      chk("t7_rdy", 32'(bus.in_ready), 32'd1);
      v = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004};
      run_frame("t7", v, 1'b0, 15'h0002, 15'h0002);
      consume("t7");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
